// File: rtl/explosion_pkg.sv
// Shared types and constants for the explosion overlay stage.
package explosion_pkg;

  localparam int SLOTS_MAX = 8;
  localparam int AGE_W     = 4;
  localparam int RING_W    = 2;

  localparam logic [11:0] COLOR_DEFAULT = 12'hF80;

  typedef struct packed {
    logic             active;
    logic [10:0]      x;
    logic [10:0]      y;
    logic [AGE_W-1:0] age;
  } expl_slot_t;

  typedef struct packed {
    logic [10:0] hcount;
    logic [10:0] vcount;
    logic        hsync;
    logic        vsync;
    logic        hblnk;
    logic        vblnk;
    logic [11:0] rgb;
  } pix_bundle_t;

endpackage

// File: rtl/explosion_slot.sv
// One explosion slot: centre/age storage, per-frame ageing and the
// two-stage square-ring hit test against the incoming pixel.
module explosion_slot
  import explosion_pkg::*;
#(
  parameter int FRAMES = 16
) (
  input  logic        pclk,
  input  logic        rst,
  input  logic        load_i,
  input  logic        tick_i,
  input  logic [10:0] x_i,
  input  logic [10:0] y_i,
  input  logic [10:0] hcount_i,
  input  logic [10:0] vcount_i,
  output logic        active_o,
  output logic        ring_hit_o
);

  expl_slot_t  slot_q, slot_d;
  logic [11:0] diff_x, diff_y;
  logic [11:0] dx_d, dy_d, dx_q, dy_q;
  logic [5:0]  r_d, r_q;
  logic        act_q;
  logic [11:0] dmax;

  // A load only ever targets an inactive slot, so it never races the ageing path.
  always_comb begin
    slot_d = slot_q;
    if (load_i) begin
      slot_d.active = 1'b1;
      slot_d.x      = x_i;
      slot_d.y      = y_i;
      slot_d.age    = '0;
    end else if (tick_i && slot_q.active) begin
      if (slot_q.age == AGE_W'(FRAMES - 1)) begin
        slot_d.active = 1'b0;
        slot_d.age    = '0;
      end else begin
        slot_d.age = slot_q.age + 1'b1;
      end
    end
  end

  // 12-bit signed differences keep off-screen ring parts from wrapping back in.
  always_comb begin
    diff_x = {1'b0, hcount_i} - {1'b0, slot_q.x};
    diff_y = {1'b0, vcount_i} - {1'b0, slot_q.y};
    dx_d   = diff_x[11] ? -diff_x : diff_x;
    dy_d   = diff_y[11] ? -diff_y : diff_y;
    r_d    = {1'b0, slot_q.age, 1'b0} + 6'd2;
  end

  always_ff @(posedge pclk) begin
    if (rst) begin
      slot_q <= '0;
      dx_q   <= '0;
      dy_q   <= '0;
      r_q    <= '0;
      act_q  <= 1'b0;
    end else begin
      slot_q <= slot_d;
      dx_q   <= dx_d;
      dy_q   <= dy_d;
      r_q    <= r_d;
      act_q  <= slot_q.active;
    end
  end

  always_comb begin
    dmax       = (dx_q > dy_q) ? dx_q : dy_q;
    ring_hit_o = act_q && (dmax <= {6'b0, r_q})
                 && ((dmax + 12'(RING_W)) >= {6'b0, r_q});
  end

  assign active_o = slot_q.active;

endmodule

// File: rtl/draw_explosion.sv
// Pixel-pipeline stage overlaying expanding square-ring explosions; the
// whole timing bundle is forwarded with a fixed two-cycle latency.
module draw_explosion
  import explosion_pkg::*;
#(
  parameter int          SLOTS  = 4,
  parameter int          FRAMES = 16,
  parameter logic [11:0] COLOR  = COLOR_DEFAULT
) (
  input  logic        pclk,
  input  logic        rst,
  input  logic        hit,
  input  logic [10:0] hit_x,
  input  logic [10:0] hit_y,
  input  logic [10:0] hcount_in,
  input  logic [10:0] vcount_in,
  input  logic        hsync_in,
  input  logic        vsync_in,
  input  logic        hblnk_in,
  input  logic        vblnk_in,
  input  logic [11:0] rgb_in,
  output logic [10:0] hcount_out,
  output logic [10:0] vcount_out,
  output logic        hsync_out,
  output logic        vsync_out,
  output logic        hblnk_out,
  output logic        vblnk_out,
  output logic [11:0] rgb_out,
  output logic        busy,
  output logic        dropped
);

  logic             vblnk_q;
  logic             tick;
  logic             free_found;
  logic             dropped_q, busy_q;
  logic [SLOTS-1:0] active, load, ring_hit;
  pix_bundle_t      s1_d, s1_q, s2_d, s2_q;

  assign tick = vblnk_in & ~vblnk_q;

  // Lowest-index free slot wins; the flags are pre-tick, so a slot expiring
  // on this same edge is not yet eligible.
  always_comb begin
    load       = '0;
    free_found = 1'b0;
    for (int i = 0; i < SLOTS; i++) begin
      if (!active[i] && !free_found) begin
        load[i]    = hit;
        free_found = 1'b1;
      end
    end
  end

  for (genvar g = 0; g < SLOTS; g++) begin : g_slot
    explosion_slot #(
      .FRAMES(FRAMES)
    ) u_slot (
      .pclk      (pclk),
      .rst       (rst),
      .load_i    (load[g]),
      .tick_i    (tick),
      .x_i       (hit_x),
      .y_i       (hit_y),
      .hcount_i  (hcount_in),
      .vcount_i  (vcount_in),
      .active_o  (active[g]),
      .ring_hit_o(ring_hit[g])
    );
  end

  always_comb begin
    s1_d = '{hcount: hcount_in, vcount: vcount_in, hsync: hsync_in,
             vsync: vsync_in, hblnk: hblnk_in, vblnk: vblnk_in, rgb: rgb_in};
    s2_d = s1_q;
    if (s1_q.hblnk || s1_q.vblnk) begin
      s2_d.rgb = '0;
    end else if (|ring_hit) begin
      s2_d.rgb = COLOR;
    end
  end

  always_ff @(posedge pclk) begin
    if (rst) begin
      vblnk_q   <= 1'b0;
      dropped_q <= 1'b0;
      busy_q    <= 1'b0;
      s1_q      <= '0;
      s2_q      <= '0;
    end else begin
      vblnk_q   <= vblnk_in;
      dropped_q <= hit & ~free_found;
      busy_q    <= |active;
      s1_q      <= s1_d;
      s2_q      <= s2_d;
    end
  end

  assign hcount_out = s2_q.hcount;
  assign vcount_out = s2_q.vcount;
  assign hsync_out  = s2_q.hsync;
  assign vsync_out  = s2_q.vsync;
  assign hblnk_out  = s2_q.hblnk;
  assign vblnk_out  = s2_q.vblnk;
  assign rgb_out    = s2_q.rgb;
  assign busy       = busy_q;
  assign dropped    = dropped_q;

endmodule

// File: tb/tb_draw_explosion.sv
// Directed bench for draw_explosion: every driven pixel queues its expected
// output, which is checked when it emerges two cycles later.
module tb_draw_explosion;

  localparam logic [11:0] COL = 12'hF80;
  localparam logic [11:0] BG  = 12'h123;

  logic        pclk = 1'b0;
  logic        rst  = 1'b1;
  logic        hit  = 1'b0;
  logic [10:0] hit_x = '0, hit_y = '0;
  logic [10:0] hcount_in = '0, vcount_in = '0;
  logic        hsync_in = 1'b0, vsync_in = 1'b0, hblnk_in = 1'b0, vblnk_in = 1'b0;
  logic [11:0] rgb_in = '0;
  logic [10:0] hcount_out, vcount_out;
  logic        hsync_out, vsync_out, hblnk_out, vblnk_out;
  logic [11:0] rgb_out;
  logic        busy, dropped;

  draw_explosion #(.SLOTS(4), .FRAMES(16), .COLOR(12'hF80)) dut (
    .pclk(pclk), .rst(rst), .hit(hit), .hit_x(hit_x), .hit_y(hit_y),
    .hcount_in(hcount_in), .vcount_in(vcount_in),
    .hsync_in(hsync_in), .vsync_in(vsync_in), .hblnk_in(hblnk_in), .vblnk_in(vblnk_in),
    .rgb_in(rgb_in),
    .hcount_out(hcount_out), .vcount_out(vcount_out),
    .hsync_out(hsync_out), .vsync_out(vsync_out), .hblnk_out(hblnk_out), .vblnk_out(vblnk_out),
    .rgb_out(rgb_out), .busy(busy), .dropped(dropped)
  );

  always #5 pclk = ~pclk;

  typedef struct {
    logic [10:0] hc;
    logic [10:0] vc;
    logic [3:0]  sb;
    logic [11:0] rgb;
    int          due;
    int          id;
  } exp_t;

  exp_t sbq[$];
  int   cyc = 0;
  int   n_assert = 0;
  int   n_fail = 0;
  int   n_id = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_assert++;
    assert (got === want) else begin
      n_fail++;
      $error("FAIL %s observed %h expected %h", tag, got, want);
    end
  endtask

  task automatic step();
    exp_t e;
    @(posedge pclk);
    #1;
    cyc++;
    if (sbq.size() > 0 && sbq[0].due == cyc) begin
      e = sbq.pop_front();
      check($sformatf("rgb#%0d", e.id), 32'(rgb_out), 32'(e.rgb));
      check($sformatf("bundle#%0d", e.id),
            32'({hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out}),
            32'({e.hc, e.vc, e.sb}));
    end
  endtask

  // sb = {hsync, vsync, hblnk, vblnk}
  task automatic pix(input int h, input int v, input logic [11:0] rgb,
                     input logic [3:0] sb, input logic [11:0] want);
    exp_t e;
    hcount_in = 11'(h);
    vcount_in = 11'(v);
    rgb_in    = rgb;
    {hsync_in, vsync_in, hblnk_in, vblnk_in} = sb;
    n_id++;
    e.hc = 11'(h); e.vc = 11'(v); e.sb = sb; e.rgb = want;
    e.due = cyc + 2; e.id = n_id;
    sbq.push_back(e);
    step();
  endtask

  task automatic idle();
    pix(2000, 1500, BG, 4'b0000, BG);
  endtask

  task automatic frame_tick();
    pix(2000, 1500, BG, 4'b0001, 12'h000);
    hit = 1'b0;
    idle();
  endtask

  task automatic hit_at(input int x, input int y);
    hit = 1'b1;
    hit_x = 11'(x);
    hit_y = 11'(y);
    idle();
    hit = 1'b0;
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    sbq.delete();
    hcount_in = 11'd5; vcount_in = 11'd7; rgb_in = 12'hFFF;
    {hsync_in, vsync_in, hblnk_in, vblnk_in} = 4'b1100;
    repeat (n) step();
    check("rst_rgb", 32'(rgb_out), 32'h0);
    check("rst_bundle", 32'({hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out}), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_dropped", 32'(dropped), 32'h0);
    rst = 1'b0;
  endtask

  initial begin
    // reset and passthrough
    do_reset(3);
    pix(100, 50, BG, 4'b1000, BG);
    pix(101, 50, 12'h456, 4'b0100, 12'h456);
    pix(102, 51, 12'h789, 4'b0010, 12'h000);
    pix(103, 51, 12'hABC, 4'b0001, 12'h000);
    idle(); idle();
    check("pass_busy", 32'(busy), 32'h0);

    // single explosion at (400,300)
    hit_at(400, 300);
    pix(402, 300, BG, 4'b0000, COL);
    pix(403, 300, BG, 4'b0000, BG);
    pix(400, 302, BG, 4'b0000, COL);
    check("single_busy", 32'(busy), 32'h1);
    repeat (3) frame_tick();
    pix(408, 295, BG, 4'b0000, COL);
    pix(400, 300, BG, 4'b0000, BG);
    pix(409, 300, BG, 4'b0000, BG);
    pix(407, 300, BG, 4'b0000, COL);
    pix(392, 308, BG, 4'b0000, COL);
    repeat (12) frame_tick();
    pix(432, 300, BG, 4'b0000, COL);
    pix(433, 300, BG, 4'b0000, BG);
    check("age15_busy", 32'(busy), 32'h1);
    frame_tick();
    check("expired_busy", 32'(busy), 32'h0);
    pix(432, 300, BG, 4'b0000, BG);
    pix(402, 300, BG, 4'b0000, BG);

    // reset mid-operation with 3 slots active and a hit during rst
    hit_at(100, 200); hit_at(200, 200); hit_at(300, 200);
    pix(102, 200, BG, 4'b0000, COL);
    pix(302, 200, BG, 4'b0000, COL);
    check("three_busy", 32'(busy), 32'h1);
    hit = 1'b1; hit_x = 11'd900; hit_y = 11'd200;
    do_reset(1);
    hit = 1'b0;
    pix(102, 200, BG, 4'b0000, BG);
    pix(202, 200, BG, 4'b0000, BG);
    pix(302, 200, BG, 4'b0000, BG);
    pix(902, 200, BG, 4'b0000, BG);
    check("post_rst_busy", 32'(busy), 32'h0);

    // overflow: five back-to-back hits
    for (int i = 0; i < 5; i++) begin
      hit = 1'b1; hit_x = 11'(100 + 100 * i); hit_y = 11'd100;
      idle();
      check($sformatf("ovf_dropped%0d", i), 32'(dropped), (i == 4) ? 32'h1 : 32'h0);
    end
    hit = 1'b0;
    idle();
    check("ovf_dropped_end", 32'(dropped), 32'h0);
    pix(102, 100, BG, 4'b0000, COL);
    pix(202, 100, BG, 4'b0000, COL);
    pix(302, 100, BG, 4'b0000, COL);
    pix(402, 100, BG, 4'b0000, COL);
    pix(502, 100, BG, 4'b0000, BG);
    check("ovf_busy", 32'(busy), 32'h1);

    // hit coincident with the tick that frees slot 2
    do_reset(1);
    hit_at(100, 600); hit_at(200, 600);
    repeat (8) frame_tick();
    hit_at(300, 600);
    repeat (8) frame_tick();
    pix(102, 600, BG, 4'b0000, BG);
    pix(318, 600, BG, 4'b0000, COL);
    hit_at(400, 600); hit_at(500, 600); hit_at(600, 600);
    repeat (7) frame_tick();
    pix(332, 600, BG, 4'b0000, COL);
    pix(416, 600, BG, 4'b0000, COL);
    hit = 1'b1; hit_x = 11'd700; hit_y = 11'd600;
    pix(2000, 1500, BG, 4'b0001, 12'h000);
    check("coinc_dropped", 32'(dropped), 32'h1);
    hit_x = 11'd800;
    idle();
    hit = 1'b0;
    check("refill_dropped", 32'(dropped), 32'h0);
    pix(802, 600, BG, 4'b0000, COL);
    pix(803, 600, BG, 4'b0000, BG);
    pix(332, 600, BG, 4'b0000, BG);
    pix(702, 600, BG, 4'b0000, BG);
    pix(418, 600, BG, 4'b0000, COL);
    hit_at(900, 600);
    check("full_again_dropped", 32'(dropped), 32'h1);

    // edge clipping and blanking
    do_reset(1);
    hit_at(0, 0);
    pix(2, 0, BG, 4'b0000, COL);
    pix(0, 2, BG, 4'b0000, COL);
    pix(2046, 0, BG, 4'b0000, BG);
    pix(0, 2046, BG, 4'b0000, BG);
    pix(2, 0, BG, 4'b0010, 12'h000);
    pix(3, 0, BG, 4'b0000, BG);
    idle(); idle();
    step(); step();
    check("queue_drained", 32'(sbq.size()), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
